// File: rtl/load_unit_fsm.sv
// MEM-stage load unit: alignment check, one word read on an SRAM-like bus,
// then byte/halfword extraction and LWL/LWR merge into a registered result.
module load_unit_fsm #(
  parameter int ADDR_W  = 32,
  parameter bit EN_LWLR = 1'b1,
  parameter bit EN_EXC  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [2:0]        ld_memread,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_rt_old,
  output logic              data_req,
  output logic [ADDR_W-1:0] data_addr,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic              res_valid,
  output logic [31:0]       res_data,
  output logic              res_exp,
  output logic [ADDR_W-1:0] res_badvaddr
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_LB  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b110;
  localparam logic [2:0] OP_LWL = 3'b011;
  localparam logic [2:0] OP_LWR = 3'b111;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, DRAIN} state_t;

  state_t      state, state_next;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] rt_q;
  logic        flush_pend;
  logic        accept;
  logic        req_misaligned;
  logic        req_reserved;
  logic        skip_bus;
  logic        killed;
  logic        load_result;

  function automatic logic [31:0] extract(input logic [2:0]  op,
                                          input logic [1:0]  n,
                                          input logic [31:0] rt,
                                          input logic [31:0] w);
    logic [15:0] half;
    logic [7:0]  bsel;
    half = n[1] ? w[31:16] : w[15:0];
    case (n)
      2'd0:    bsel = w[7:0];
      2'd1:    bsel = w[15:8];
      2'd2:    bsel = w[23:16];
      default: bsel = w[31:24];
    endcase
    case (op)
      OP_LW:   extract = w;
      OP_LH:   extract = {{16{half[15]}}, half};
      OP_LHU:  extract = {16'd0, half};
      OP_LB:   extract = {{24{bsel[7]}}, bsel};
      OP_LBU:  extract = {24'd0, bsel};
      OP_LWL: begin
        case (n)
          2'd0:    extract = {w[7:0], rt[23:0]};
          2'd1:    extract = {w[15:0], rt[15:0]};
          2'd2:    extract = {w[23:0], rt[7:0]};
          default: extract = w;
        endcase
      end
      OP_LWR: begin
        case (n)
          2'd0:    extract = w;
          2'd1:    extract = {rt[31:24], w[31:8]};
          2'd2:    extract = {rt[31:16], w[31:16]};
          default: extract = {rt[31:8], w[31:24]};
        endcase
      end
      default: extract = 32'd0;
    endcase
  endfunction

  assign accept = (state == IDLE) && ld_valid && !flush;

  always_comb begin
    req_misaligned = 1'b0;
    req_reserved   = 1'b0;
    case (ld_memread)
      OP_LW:          req_misaligned = (ld_addr[1:0] != 2'b00);
      OP_LH, OP_LHU:  req_misaligned = ld_addr[0];
      OP_LWL, OP_LWR: req_reserved   = !EN_LWLR;
      OP_LB, OP_LBU:  req_reserved   = 1'b0;
      default:        req_reserved   = 1'b1;
    endcase
  end

  // Misaligned loads never touch the bus, whether or not they raise AdEL.
  assign skip_bus = req_reserved || req_misaligned;
  // A flush seen on any REQ cycle dooms the load once the address handshake ends.
  assign killed   = flush_pend || flush;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = skip_bus ? RESP : REQ;
      REQ: begin
        if (data_addr_ok) begin
          if (data_data_ok) state_next = killed ? IDLE : RESP;
          else              state_next = killed ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (data_data_ok) state_next = flush ? IDLE : RESP;
        else if (flush)   state_next = DRAIN;
      end
      RESP:    state_next = IDLE;
      DRAIN:   if (data_data_ok) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign load_result = (state_next == RESP) && ((state == REQ) || (state == WAIT));
  assign ld_ready    = (state == IDLE);
  assign data_req    = (state == REQ);
  assign res_valid   = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= 3'd0;
      off_q        <= 2'd0;
      rt_q         <= 32'd0;
      flush_pend   <= 1'b0;
      data_addr    <= '0;
      res_data     <= 32'd0;
      res_exp      <= 1'b0;
      res_badvaddr <= '0;
    end else begin
      if (accept) begin
        op_q       <= ld_memread;
        off_q      <= ld_addr[1:0];
        rt_q       <= ld_rt_old;
        flush_pend <= 1'b0;
        data_addr  <= {ld_addr[ADDR_W-1:2], 2'b00};
        res_exp    <= 1'b0;
        if (skip_bus) begin
          res_data <= 32'd0;
          if (req_misaligned && EN_EXC) begin
            res_exp      <= 1'b1;
            res_badvaddr <= ld_addr;
          end
        end
      end
      if ((state == REQ) && flush) flush_pend <= 1'b1;
      if (load_result) res_data <= extract(op_q, off_q, rt_q, data_rdata);
    end
  end

endmodule
